// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst/response encodings, the write-master FSM
// state type and a helper that turns a data-bus width into an AxSIZE code.
`timescale 1ns/1ps
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // One-hot write FSM encoding; a stray multi-hot value falls back to idle
  typedef enum logic [3:0] {
    WR_IDLE = 4'b0001,
    WR_CMD  = 4'b0010,
    WR_DATA = 4'b0100,
    WR_RESP = 4'b1000
  } wr_state_e;

  // AxSIZE is log2 of the number of bytes per beat
  function automatic logic [2:0] axi_size_from_width(input int unsigned width);
    logic [2:0] size;
    case (width)
      512:     size = 3'd6;
      256:     size = 3'd5;
      128:     size = 3'd4;
      64:      size = 3'd3;
      default: size = 3'd2;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/wr_master.sv
// AXI4 write-channel master: takes one burst request from the write buffer,
// issues the AW beat, streams len+1 W beats straight from the buffer and
// reports completion once the B response arrives. One burst in flight.
// Optional build macro WR_MASTER_BRESP_CHK_EN enables the sticky bresp/bid
// error flag on axi_b_err; without it axi_b_err is constant 0.
`timescale 1ns/1ps
module wr_master
  import axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        reset,
  // request / data interface toward the write buffer
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  input  logic                        axi_aw_req_en,
  input  logic [7:0]                  axi_aw_burst_len,
  output logic                        axi_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  input  logic                        axi_w_valid,
  output logic                        axi_w_ready,
  output logic                        axi_b_done,
  output logic                        axi_b_err,
  // AW channel
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [3:0]                  m_axi_awid,
  output logic [1:0]                  m_axi_awburst,
  output logic [2:0]                  m_axi_awsize,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic [0:0]                  m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  // W channel
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  // B channel
  input  logic [3:0]                  m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);

  localparam logic [2:0] AW_SIZE = axi_size_from_width(AXI_DATA_WIDTH);

  wr_state_e                 state_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]                awlen_q;
  logic [7:0]                beat_cnt_q;
  logic                      awvalid_q;
  logic                      bready_q;
  logic                      b_done_q;

  logic in_data;
  logic w_hs;
  logic w_last;

  assign in_data = (state_q == WR_DATA);
  assign w_last  = in_data && (beat_cnt_q == awlen_q);
  assign w_hs    = in_data && axi_w_valid && m_axi_wready;

  // Fixed AW attributes: single-ID, INCR, full-width beats, full strobes
  assign m_axi_awid    = 4'd0;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awsize  = AW_SIZE;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_wstrb   = '1;

  // Buffer and W channel are wired through only while streaming data
  assign axi_aw_ready  = (state_q == WR_IDLE);
  assign m_axi_wvalid  = in_data && axi_w_valid;
  assign axi_w_ready   = in_data && m_axi_wready;
  assign m_axi_wdata   = in_data ? axi_w_data : '0;
  assign m_axi_wlast   = w_last;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_bready  = bready_q;
  assign axi_b_done    = b_done_q;

  // Burst sequencer: accept request, hold AW, count W beats, await B
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q    <= WR_IDLE;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= 8'd0;
      beat_cnt_q <= 8'd0;
      bready_q   <= 1'b0;
      b_done_q   <= 1'b0;
    end else begin
      b_done_q <= 1'b0;
      case (state_q)
        WR_IDLE: begin
          if (axi_aw_req_en) begin
            awaddr_q   <= axi_aw_addr;
            awlen_q    <= axi_aw_burst_len;
            awvalid_q  <= 1'b1;
            beat_cnt_q <= 8'd0;
            state_q    <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            state_q   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            if (w_last) begin
              bready_q <= 1'b1;
              state_q  <= WR_RESP;
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            b_done_q <= 1'b1;
            state_q  <= WR_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          bready_q  <= 1'b0;
          state_q   <= WR_IDLE;
        end
      endcase
    end
  end

`ifdef WR_MASTER_BRESP_CHK_EN
  logic b_err_q;

  // Sticky error flag, raised on the same edge that launches b_done
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      b_err_q <= 1'b0;
    end else if ((state_q == WR_RESP) && m_axi_bvalid &&
                 ((m_axi_bresp != AXI_RESP_OKAY) || (m_axi_bid != 4'd0))) begin
      b_err_q <= 1'b1;
    end
  end

  assign axi_b_err = b_err_q;
`else
  logic unused_b_fields;

  assign unused_b_fields = ^{m_axi_bresp, m_axi_bid};
  assign axi_b_err       = 1'b0;
`endif

endmodule

// File: tb/tb_wr_master.sv
// Randomized bench for wr_master. A transaction-level model (outstanding
// flag, beat count, sticky error) predicts every output each cycle; a few
// directed bursts pin the model with hand-computed numbers.
`timescale 1ns/1ps
module tb_wr_master;

  localparam int DW     = 128;
  localparam int AW     = 32;
  localparam int BUDGET = 4000;

  logic            aclk;
  logic            reset;
  logic [AW-1:0]   axi_aw_addr;
  logic            axi_aw_req_en;
  logic [7:0]      axi_aw_burst_len;
  logic            axi_aw_ready;
  logic [DW-1:0]   axi_w_data;
  logic            axi_w_valid;
  logic            axi_w_ready;
  logic            axi_b_done;
  logic            axi_b_err;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [3:0]      m_axi_awid;
  logic [1:0]      m_axi_awburst;
  logic [2:0]      m_axi_awsize;
  logic [2:0]      m_axi_awprot;
  logic [3:0]      m_axi_awqos;
  logic [0:0]      m_axi_awlock;
  logic [3:0]      m_axi_awcache;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic [3:0]      m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;

  int checks   = 0;
  int failures = 0;

  wr_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .reset(reset),
    .axi_aw_addr(axi_aw_addr), .axi_aw_req_en(axi_aw_req_en),
    .axi_aw_burst_len(axi_aw_burst_len), .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_done(axi_b_done), .axi_b_err(axi_b_err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awid(m_axi_awid), .m_axi_awburst(m_axi_awburst), .m_axi_awsize(m_axi_awsize),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Buffer payload for beat k of burst id: distinct per burst and per beat
  function automatic logic [DW-1:0] dataFor(input int id, input int k);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++)
      d[i*32 +: 32] = (id * 32'h9E3779B1) ^ (k * 32'h85EBCA6B) ^ (i << 28) ^ 32'h5A5A0000;
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            outstanding = 0;
  bit            awDone      = 0;
  int            beats       = 0;
  int            curLen      = 0;
  int            curId       = 0;
  logic [AW-1:0] curAddr     = '0;
  bit            doneNext    = 0;
  bit            errSticky   = 0;
  int            burstCount  = 0;
  // statistics used by the directed pins
  int            donePulses  = 0;
  int            wlastCount  = 0;
  int            awRun       = 0;
  int            lastBeats   = 0;
  int            lastWlast   = 0;
  int            lastAwRun   = 0;
  logic [AW-1:0] lastAwAddr  = '0;
  int            lastAwLen   = 0;
  bit            inData;
  bit            bWait;

  always @(negedge aclk) begin
    if (reset) begin
      checkOutput("rst_awvalid", DW'(m_axi_awvalid), '0);
      checkOutput("rst_awaddr", DW'(m_axi_awaddr), '0);
      checkOutput("rst_awlen", DW'(m_axi_awlen), '0);
      checkOutput("rst_wvalid", DW'(m_axi_wvalid), '0);
      checkOutput("rst_bready", DW'(m_axi_bready), '0);
      checkOutput("rst_b_done", DW'(axi_b_done), '0);
      checkOutput("rst_b_err", DW'(axi_b_err), '0);
      outstanding = 0; awDone = 0; beats = 0; doneNext = 0; errSticky = 0;
    end else begin
      inData = outstanding && awDone && (beats <= curLen);
      bWait  = outstanding && (beats == curLen + 1);
      if (axi_b_done) donePulses++;
      checkOutput("aw_ready", DW'(axi_aw_ready), DW'(!outstanding));
      checkOutput("awvalid", DW'(m_axi_awvalid), DW'(outstanding && !awDone));
      if (outstanding && !awDone) begin
        checkOutput("awaddr", DW'(m_axi_awaddr), DW'(curAddr));
        checkOutput("awlen", DW'(m_axi_awlen), DW'(curLen));
      end
      checkOutput("wvalid", DW'(m_axi_wvalid), DW'(inData && axi_w_valid));
      checkOutput("w_ready", DW'(axi_w_ready), DW'(inData && m_axi_wready));
      checkOutput("wdata_pass", m_axi_wdata, inData ? axi_w_data : '0);
      checkOutput("bready", DW'(m_axi_bready), DW'(bWait));
      checkOutput("b_done", DW'(axi_b_done), DW'(doneNext));
      checkOutput("b_err", DW'(axi_b_err), DW'(errSticky));

      doneNext = 0;
      if (!outstanding) begin
        if (axi_aw_req_en) begin
          outstanding = 1; awDone = 0; beats = 0; wlastCount = 0; awRun = 0;
          curAddr = axi_aw_addr; curLen = int'(axi_aw_burst_len);
          curId = burstCount; burstCount++;
        end
      end else if (!awDone) begin
        awRun++;
        if (m_axi_awready) begin
          awDone = 1; lastAwRun = awRun;
          lastAwAddr = m_axi_awaddr; lastAwLen = int'(m_axi_awlen);
          checkOutput("awsize", DW'(m_axi_awsize), DW'($clog2(DW/8)));
          checkOutput("awburst", DW'(m_axi_awburst), DW'(2'b01));
          checkOutput("aw_misc", DW'({m_axi_awid, m_axi_awprot, m_axi_awqos, m_axi_awlock, m_axi_awcache}), '0);
          checkOutput("wstrb", DW'(m_axi_wstrb), {(DW/8){1'b1}});
        end
      end else if (inData) begin
        if (axi_w_valid && m_axi_wready) begin
          checkOutput("wdata_beat", m_axi_wdata, dataFor(curId, beats));
          checkOutput("wlast", DW'(m_axi_wlast), DW'(beats == curLen));
          if (m_axi_wlast) wlastCount++;
          beats++;
        end
      end else if (bWait && m_axi_bvalid) begin
        outstanding = 0; doneNext = 1;
        lastBeats = beats; lastWlast = wlastCount;
`ifdef WR_MASTER_BRESP_CHK_EN
        if (m_axi_bresp != 2'b00 || m_axi_bid != 4'd0) errSticky = 1;
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  int issued = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  // One burst as seen from buffer + slave; abortAt>=0 resets after that many beats
  task automatic applyStimulus(input logic [AW-1:0] addr, input int len, input int wMode,
                               input int awHold, input int bDelay, input logic [1:0] bresp,
                               input logic [3:0] bid, input int abortAt);
    int sent = 0, awWait = 0, bCnt = 0, cyc = 0, myId = 0;
    bit accepted = 0, done = 0, aborted = 0;
    axi_aw_addr = addr; axi_aw_burst_len = 8'(len); axi_aw_req_en = 1'b1;
    while (!done && !aborted && cyc < BUDGET) begin
      m_axi_awready = accepted && (awWait >= awHold);
      case (wMode)
        0: begin axi_w_valid = 1'b1; m_axi_wready = 1'b1; end
        1: begin axi_w_valid = ($urandom_range(0, 3) != 0); m_axi_wready = cyc[0]; end
        default: begin axi_w_valid = 1'($urandom_range(0, 1)); m_axi_wready = 1'($urandom_range(0, 1)); end
      endcase
      axi_w_data = dataFor(myId, sent);
      if (sent == len + 1) begin
        m_axi_bvalid = (bCnt >= bDelay); m_axi_bresp = bresp; m_axi_bid = bid;
      end else begin
        m_axi_bvalid = ($urandom_range(0, 3) == 0); m_axi_bresp = 2'b11; m_axi_bid = 4'hF;
      end
      @(negedge aclk);
      if (axi_aw_req_en && axi_aw_ready) begin accepted = 1; myId = issued; issued++; end
      if (m_axi_awvalid && !m_axi_awready) awWait++;
      if (axi_w_valid && axi_w_ready) sent++;
      else if (sent == len + 1) bCnt++;
      if (m_axi_bvalid && m_axi_bready) done = 1;
      @(posedge aclk); #1;
      if (accepted) axi_aw_req_en = 1'b0;
      if (abortAt >= 0 && sent == abortAt) aborted = 1;
      cyc++;
    end
    axi_aw_req_en = 1'b0; axi_w_valid = 1'b0; m_axi_wready = 1'b0;
    m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = 4'd0;
    if (cyc >= BUDGET) begin
      checks++; failures++;
      $display("[TB] FAIL timeout: got %0d beats expected %0d within %0d cycles", sent, len + 1, BUDGET);
    end
    if (aborted) begin
      reset = 1'b1;
      @(negedge aclk); @(negedge aclk);
      @(posedge aclk); #1;
      reset = 1'b0;
    end
  endtask

  int d0;
  int rlen;
  bit expErr;

  initial begin
    reset = 1'b1;
    axi_aw_addr = '0; axi_aw_req_en = 1'b0; axi_aw_burst_len = 8'd0;
    axi_w_data = '0; axi_w_valid = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bid = 4'd0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);

    // single beat, immediate awready, B two cycles after wlast
    d0 = donePulses;
    applyStimulus(32'h0000_1000, 0, 0, 0, 2, 2'b00, 4'd0, -1);
    idle(2);
    checkOutput("t1_done_pulses", DW'(donePulses - d0), DW'(1));
    checkOutput("t1_beats", DW'(lastBeats), DW'(1));
    checkOutput("t1_wlast_count", DW'(lastWlast), DW'(1));
    checkOutput("t1_awaddr", DW'(lastAwAddr), DW'(32'h0000_1000));
    checkOutput("t1_awlen", DW'(lastAwLen), DW'(0));

    // 16 beats with toggling wready and buffer gaps
    applyStimulus(32'h0000_2000, 15, 1, 1, 0, 2'b00, 4'd0, -1);
    idle(2);
    checkOutput("t2_beats", DW'(lastBeats), DW'(16));
    checkOutput("t2_wlast_count", DW'(lastWlast), DW'(1));

    // maximum burst length
    applyStimulus(32'h0001_0000, 255, 2, 0, 1, 2'b00, 4'd0, -1);
    idle(2);
    checkOutput("t3_beats", DW'(lastBeats), DW'(256));
    checkOutput("t3_wlast_count", DW'(lastWlast), DW'(1));
    checkOutput("t3_awlen", DW'(lastAwLen), DW'(255));

    // awready withheld for 10 cycles
    applyStimulus(32'h0000_3000, 3, 0, 10, 0, 2'b00, 4'd0, -1);
    idle(2);
    checkOutput("t4_awvalid_cycles", DW'(lastAwRun), DW'(11));
    checkOutput("t4_beats", DW'(lastBeats), DW'(4));

    // SLVERR followed by an OKAY burst
`ifdef WR_MASTER_BRESP_CHK_EN
    expErr = 1'b1;
`else
    expErr = 1'b0;
`endif
    applyStimulus(32'h0000_4000, 2, 0, 0, 1, 2'b10, 4'd0, -1);
    idle(2);
    checkOutput("t5_err_after_slverr", DW'(axi_b_err), DW'(expErr));
    applyStimulus(32'h0000_5000, 1, 0, 0, 0, 2'b00, 4'd0, -1);
    idle(2);
    checkOutput("t5_err_after_okay", DW'(axi_b_err), DW'(expErr));

    // randomized bursts
    for (int n = 0; n < 20; n++) begin
      rlen = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      applyStimulus($urandom & 32'hFFFF_FFF0, rlen, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00,
                    ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h0, -1);
      idle(1);
      checkOutput("rand_beats", DW'(lastBeats), DW'(rlen + 1));
    end

    // reset after beat 5 of 8, then a clean burst
    idle(2);
    d0 = donePulses;
    applyStimulus(32'h0000_6000, 7, 0, 0, 0, 2'b00, 4'd0, 5);
    idle(3);
    checkOutput("t6_no_done", DW'(donePulses - d0), DW'(0));
    checkOutput("t6_err_cleared", DW'(axi_b_err), DW'(0));
    checkOutput("t6_aw_ready", DW'(axi_aw_ready), DW'(1));
    applyStimulus(32'h0000_7000, 3, 0, 0, 1, 2'b00, 4'd0, -1);
    idle(2);
    checkOutput("t6_done_after", DW'(donePulses - d0), DW'(1));
    checkOutput("t6_beats_after", DW'(lastBeats), DW'(4));

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
